// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM states for the sequential ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01100;
    localparam logic [4:0] OP_SRL1 = 5'b00000;
    localparam logic [4:0] OP_SLL1 = 5'b10000;
    localparam logic [4:0] OP_MUL  = 5'b00100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops (no MUL); purely combinational, zero latency.
// No flow control: the sequencer samples these outputs on accept.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       f,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             v,
    output logic             err
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        y    = '0;
        c    = 1'b0;
        v    = 1'b0;
        err  = 1'b0;
        case (f)
            OP_ADD: begin
                y = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // diff[WIDTH] is the borrow, set exactly when a < b unsigned
                y = diff[WIDTH-1:0];
                c = diff[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_SRL1: begin
                y = {1'b0, a[WIDTH-1:1]};
                c = a[0];
            end
            OP_SLL1: begin
                y = {a[WIDTH-2:0], 1'b0};
                c = a[WIDTH-1];
            end
            OP_MUL:  y = '0;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; 1-cycle ops, WIDTH+1-cycle shift-add MUL.
// Results hold in DONE until out_ready; in_ready drops while a MUL iterates.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_err
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] y_hi_q, y_hi_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] comb_y;
    logic             comb_c;
    logic             comb_v;
    logic             comb_err;

    logic               accept;
    logic               is_mul;
    logic               last_iter;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] acc_step;

    alu_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .a   (a),
        .b   (b),
        .f   (f),
        .y   (comb_y),
        .c   (comb_c),
        .v   (comb_v),
        .err (comb_err)
    );

    assign accept    = in_valid && in_ready;
    assign is_mul    = (f == OP_MUL);
    assign last_iter = (state_q == MUL) && (count_q == CW'(WIDTH - 1));

    // acc = {partial high half, remaining multiplier bits}; carry of the add shifts in at the top
    always_comb begin
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {add_sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_mul ? MUL : DONE;
            MUL:  if (last_iter) state_d = DONE;
            DONE: begin
                if (accept)         state_d = is_mul ? MUL : DONE;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        count_d = count_q;
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        err_d   = err_q;
        if (accept) begin
            if (is_mul) begin
                mcand_d = a;
                acc_d   = {{WIDTH{1'b0}}, b};
                count_d = '0;
            end else begin
                y_d    = comb_y;
                y_hi_d = '0;
                z_d    = (comb_y == '0);
                c_d    = comb_c;
                v_d    = comb_v;
                err_d  = comb_err;
            end
        end else if (state_q == MUL) begin
            acc_d   = acc_step;
            count_d = count_q + CW'(1);
            if (last_iter) begin
                y_d    = acc_step[WIDTH-1:0];
                y_hi_d = acc_step[2*WIDTH-1:WIDTH];
                z_d    = (acc_step[WIDTH-1:0] == '0);
                c_d    = (acc_step[2*WIDTH-1:WIDTH] != '0);
                v_d    = 1'b0;
                err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
            count_q <= '0;
            y_q     <= '0;
            y_hi_q  <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
            err_q   <= err_d;
        end
    end

    assign y        = y_q;
    assign y_hi     = y_hi_q;
    assign flag_z   = z_q;
    assign flag_c   = c_q;
    assign flag_v   = v_q;
    assign flag_err = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with an arithmetic reference model and per-cycle output compare.
module tb_alu_seq;

    localparam int W = 4;
    localparam logic [4:0] F_ADD = 5'b00010;
    localparam logic [4:0] F_SUB = 5'b00011;
    localparam logic [4:0] F_AND = 5'b01000;
    localparam logic [4:0] F_OR  = 5'b01100;
    localparam logic [4:0] F_SRL = 5'b00000;
    localparam logic [4:0] F_SLL = 5'b10000;
    localparam logic [4:0] F_MUL = 5'b00100;
    localparam logic [4:0] F_BAD = 5'b11111;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   f;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [W-1:0] y_hi;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;
    logic         flag_err;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    typedef struct {
        int y;
        int y_hi;
        int z;
        int c;
        int v;
        int err;
        int due;
    } exp_t;

    exp_t q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_err  (flag_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // due = edge count after which the result must be visible
    function automatic exp_t model(input logic [4:0] fo, input int ai, input int bi, input int now);
        exp_t e;
        int m, h, sa, sb, r;
        m  = 1 << W;
        h  = m / 2;
        sa = (ai >= h) ? ai - m : ai;
        sb = (bi >= h) ? bi - m : bi;
        e.y = 0; e.y_hi = 0; e.c = 0; e.v = 0; e.err = 0;
        e.due = now + 1;
        case (fo)
            F_ADD: begin
                r = ai + bi; e.y = r % m; e.c = int'(r >= m);
                r = sa + sb; e.v = int'(r >= h || r < -h);
            end
            F_SUB: begin
                r = ai - bi; e.y = (r + m) % m; e.c = int'(ai < bi);
                r = sa - sb; e.v = int'(r >= h || r < -h);
            end
            F_AND: e.y = ai & bi;
            F_OR:  e.y = ai | bi;
            F_SRL: begin e.y = ai / 2; e.c = ai % 2; end
            F_SLL: begin e.y = (2 * ai) % m; e.c = int'(ai >= h); end
            F_MUL: begin
                r = ai * bi; e.y = r % m; e.y_hi = r / m;
                e.c = int'(e.y_hi != 0); e.due = now + 1 + W;
            end
            default: e.err = 1;
        endcase
        e.z = int'(e.y == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   exp_valid;
        int   exp_ready;
        if (rst) begin
            q.delete();
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_y", int'(y), 0);
            chk("rst_y_hi", int'(y_hi), 0);
            chk("rst_flags", int'({flag_z, flag_c, flag_v, flag_err}), 0);
        end else begin
            exp_valid = int'(q.size() != 0 && edges >= q[0].due);
            if (q.size() == 0)       exp_ready = 1;
            else if (exp_valid != 0) exp_ready = int'(out_ready);
            else                     exp_ready = 0;
            chk("out_valid", int'(out_valid), exp_valid);
            chk("in_ready", int'(in_ready), exp_ready);
            if (exp_valid != 0 && out_valid) begin
                e = q[0];
                chk("y", int'(y), e.y);
                chk("y_hi", int'(y_hi), e.y_hi);
                chk("flag_z", int'(flag_z), e.z);
                chk("flag_c", int'(flag_c), e.c);
                chk("flag_v", int'(flag_v), e.v);
                chk("flag_err", int'(flag_err), e.err);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(f, int'(a), int'(b), edges));
        end
    end

    // Returns 1 time unit after the accepting edge.
    task automatic op(input logic [4:0] fo, input int ai, input int bi);
        int n;
        in_valid = 1'b1;
        f = fo;
        a = ai[W-1:0];
        b = bi[W-1:0];
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int sub_b [4] = '{1, 2, 3, 12};
        int sub_y [4] = '{14, 13, 12, 3};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; f = '0;

        e = model(F_ADD, 15, 1, 0);
        chk("model_add_y", e.y, 0);
        chk("model_add_c", e.c, 1);
        e = model(F_MUL, 15, 15, 0);
        chk("model_mul_hi", e.y_hi, 14);
        chk("model_mul_due", e.due, 5);
        e = model(F_SUB, 8, 1, 0);
        chk("model_sub_v", e.v, 1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        op(F_ADD, 15, 1);
        chk("add_valid", int'(out_valid), 1);
        chk("add_y", int'(y), 0);
        chk("add_z", int'(flag_z), 1);
        chk("add_c", int'(flag_c), 1);
        chk("add_v", int'(flag_v), 0);
        chk("add_err", int'(flag_err), 0);
        step();

        for (int i = 0; i < 4; i++) begin
            op(F_SUB, 15, sub_b[i]);
            chk("sub_y", int'(y), sub_y[i]);
            chk("sub_c", int'(flag_c), 0);
            chk("sub_in_ready", int'(in_ready), 1);
        end

        op(F_MUL, 15, 15);
        a = '0;
        b = '0;
        for (int i = 0; i < W; i++) begin
            chk("mul_busy_ready", int'(in_ready), 0);
            chk("mul_busy_valid", int'(out_valid), 0);
            step();
        end
        chk("mul_valid", int'(out_valid), 1);
        chk("mul_y", int'(y), 1);
        chk("mul_y_hi", int'(y_hi), 14);
        chk("mul_c", int'(flag_c), 1);
        chk("mul_z", int'(flag_z), 0);
        step();

        out_ready = 1'b0;
        op(F_ADD, 7, 1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_y", int'(y), 8);
            chk("bp_v", int'(flag_v), 1);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_done_valid", int'(out_valid), 0);
        chk("bp_done_ready", int'(in_ready), 1);

        op(F_MUL, 3, 5);
        step();
        rst = 1'b1;
        #1;
        chk("abort_y", int'(y), 0);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        step();
        rst = 1'b0;
        op(F_MUL, 3, 5);
        repeat (W) step();
        chk("mul2_valid", int'(out_valid), 1);
        chk("mul2_y", int'(y), 15);
        chk("mul2_y_hi", int'(y_hi), 0);

        op(F_BAD, 9, 9);
        chk("bad_y", int'(y), 0);
        chk("bad_err", int'(flag_err), 1);
        chk("bad_z", int'(flag_z), 1);
        chk("bad_cv", int'({flag_c, flag_v}), 0);
        op(F_SLL, 9, 0);
        chk("sll_y", int'(y), 2);
        chk("sll_c", int'(flag_c), 1);
        op(F_SRL, 9, 0);
        chk("srl_y", int'(y), 4);
        chk("srl_c", int'(flag_c), 1);
        op(F_AND, 12, 10);
        chk("and_y", int'(y), 8);
        op(F_OR, 12, 10);
        chk("or_y", int'(y), 14);
        op(F_SUB, 8, 1);
        chk("sub_ovf_y", int'(y), 7);
        chk("sub_ovf_v", int'(flag_v), 1);
        op(F_SUB, 2, 5);
        chk("sub_borrow_c", int'(flag_c), 1);

        op(F_MUL, 2, 3);
        op(F_ADD, 1, 1);
        chk("held_add_y", int'(y), 2);
        repeat (3) step();
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
